// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle RV32I ALU with bit-serial shifter; RV32M mul/div group compiled in with ALU_MULDIV_EN
module alu_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  invalid,
    output logic                  busy,
    output logic                  done
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef ALU_MULDIV_EN
    localparam logic [1:0] S_MUL   = 2'd2;
    localparam logic [1:0] S_DIV   = 2'd3;
`endif

    logic [1:0]    state;
    logic [SW-1:0] cnt;
    logic [1:0]    kind_q;
    logic [W-1:0]  lo_q;
    logic [W-1:0]  out_q;
    logic          invalid_q;
    logic          done_q;

    logic [SW-1:0] shamt;
    logic [W-1:0]  base_res;
    logic          base_ok;
    logic          is_shift;

    assign shamt   = in_b[SW-1:0];
    assign out     = out_q;
    assign invalid = invalid_q;
    assign done    = done_q;
    assign busy    = (state != S_IDLE);

    // k = op[3:2]: 00 SLL, 01 SRL, 11 SRA
    function automatic logic [W-1:0] shift1(input logic [W-1:0] v, input logic [1:0] k);
        if (!k[0])
            shift1 = {v[W-2:0], 1'b0};
        else if (k[1])
            shift1 = {v[W-1], v[W-1:1]};
        else
            shift1 = {1'b0, v[W-1:1]};
    endfunction

    always_comb begin
        base_res = '0;
        base_ok  = 1'b1;
        is_shift = 1'b0;
        case (op[3:0])
            4'b0000: base_res = in_a + in_b;
            4'b1000: base_res = in_a - in_b;
            4'b0010: base_res = {{(W-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            4'b0011: base_res = {{(W-1){1'b0}}, in_a < in_b};
            4'b0100: base_res = in_a ^ in_b;
            4'b0110: base_res = in_a | in_b;
            4'b0111: base_res = in_a & in_b;
            4'b0001, 4'b0101, 4'b1101: begin
                base_res = in_a;
                is_shift = 1'b1;
            end
            default: base_ok = 1'b0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic [W-1:0]   hi_q;
    logic [W-1:0]   mb_q;
    logic           neg_q;
    logic           negr_q;
    logic           low_q;
    logic           rem_q;
    logic           sgn_a;
    logic           sgn_b;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W-1:0]   min_neg;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rmd;

    // Shift-add step: {hi,lo} holds partial product over the shrinking multiplier
    function automatic logic [2*W-1:0] mul_step(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                                input logic [W-1:0] m);
        logic [W:0] sum;
        sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(W+1){1'b0}});
        mul_step = {sum, lo[W-1:1]};
    endfunction

    // Restoring step: r is the partial remainder, q shifts dividend out and quotient in
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r, input logic [W-1:0] q,
                                                input logic [W-1:0] d);
        logic [W:0] t;
        logic [W:0] diff;
        t    = {r, q[W-1]};
        diff = t - {1'b0, d};
        if (!diff[W])
            div_step = {diff[W-1:0], q[W-2:0], 1'b1};
        else
            div_step = {t[W-1:0], q[W-2:0], 1'b0};
    endfunction

    assign sgn_a   = (op[2:0] == 3'b001) || (op[2:0] == 3'b010) ||
                     (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
    assign sgn_b   = (op[2:0] == 3'b001) || (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
    assign a_neg   = sgn_a & in_a[W-1];
    assign b_neg   = sgn_b & in_b[W-1];
    assign mag_a   = a_neg ? -in_a : in_a;
    assign mag_b   = b_neg ? -in_b : in_b;
    assign min_neg = {1'b1, {(W-1){1'b0}}};
    assign prod    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo     = neg_q ? -lo_q : lo_q;
    assign rmd     = negr_q ? -hi_q : hi_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            kind_q    <= '0;
            lo_q      <= '0;
            out_q     <= '0;
            invalid_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef ALU_MULDIV_EN
            hi_q      <= '0;
            mb_q      <= '0;
            neg_q     <= 1'b0;
            negr_q    <= 1'b0;
            low_q     <= 1'b0;
            rem_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        kind_q <= op[3:2];
                        if (!op[4]) begin
                            if (!base_ok) begin
                                out_q     <= '0;
                                invalid_q <= 1'b1;
                                done_q    <= 1'b1;
                            end else if (is_shift && shamt > SW'(1)) begin
                                // first bit is shifted on the accept edge itself
                                lo_q  <= shift1(in_a, op[3:2]);
                                cnt   <= shamt - SW'(1);
                                state <= S_SHIFT;
                            end else begin
                                out_q     <= (is_shift && shamt == SW'(1)) ? shift1(in_a, op[3:2])
                                                                           : base_res;
                                invalid_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end else begin
`ifdef ALU_MULDIV_EN
                            if (op[3]) begin
                                out_q     <= '0;
                                invalid_q <= 1'b1;
                                done_q    <= 1'b1;
                            end else if (!op[2]) begin
                                {hi_q, lo_q} <= mul_step('0, mag_b, mag_a);
                                mb_q  <= mag_a;
                                neg_q <= a_neg ^ b_neg;
                                low_q <= (op[1:0] == 2'b00);
                                cnt   <= SW'(W - 1);
                                state <= S_MUL;
                            end else if (in_b == '0) begin
                                out_q     <= op[1] ? in_a : '1;
                                invalid_q <= 1'b0;
                                done_q    <= 1'b1;
                            end else if (!op[0] && in_a == min_neg && in_b == '1) begin
                                out_q     <= op[1] ? '0 : in_a;
                                invalid_q <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                {hi_q, lo_q} <= div_step('0, mag_a, mag_b);
                                mb_q   <= mag_b;
                                neg_q  <= a_neg ^ b_neg;
                                negr_q <= a_neg;
                                rem_q  <= op[1];
                                cnt    <= SW'(W - 1);
                                state  <= S_DIV;
                            end
`else
                            out_q     <= '0;
                            invalid_q <= 1'b1;
                            done_q    <= 1'b1;
`endif
                        end
                    end
                end
                S_SHIFT: begin
                    lo_q <= shift1(lo_q, kind_q);
                    cnt  <= cnt - SW'(1);
                    if (cnt == SW'(1)) begin
                        out_q     <= shift1(lo_q, kind_q);
                        invalid_q <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
`ifdef ALU_MULDIV_EN
                S_MUL: begin
                    if (cnt != '0) begin
                        {hi_q, lo_q} <= mul_step(hi_q, lo_q, mb_q);
                        cnt          <= cnt - SW'(1);
                    end else begin
                        out_q     <= low_q ? prod[W-1:0] : prod[2*W-1:W];
                        invalid_q <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_DIV: begin
                    if (cnt != '0) begin
                        {hi_q, lo_q} <= div_step(hi_q, lo_q, mb_q);
                        cnt          <= cnt - SW'(1);
                    end else begin
                        out_q     <= rem_q ? rmd : quo;
                        invalid_q <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq; M-op vectors run when ALU_MULDIV_EN is defined
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [4:0]   op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] out;
    logic         invalid;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    alu_seq #(.DATA_WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .in_a    (in_a),
        .in_b    (in_b),
        .out     (out),
        .invalid (invalid),
        .busy    (busy),
        .done    (done)
    );

    typedef struct {
        string        tag;
        logic [W-1:0] out;
        logic         inv;
        int           due;
        int           lat;
    } exp_t;

    exp_t sbq[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                busy_cnt = 0;
            end else if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: out %h", out);
                end else begin
                    e = sbq.pop_front();
                    check({e.tag, " out"}, out, e.out);
                    check({e.tag, " invalid"}, W'(invalid), W'(e.inv));
                    check({e.tag, " latency_cycle"}, W'(cyc), W'(e.due));
                    check({e.tag, " busy_cycles"}, W'(busy_cnt), W'(e.lat - 1));
                    check({e.tag, " busy_at_done"}, W'(busy), '0);
                end
                busy_cnt = 0;
            end else if (busy === 1'b1) begin
                busy_cnt++;
            end
        end
    end

    task automatic issue(input string tag, input logic [4:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eo, input logic ei,
                         input int lat);
        exp_t e;
        @(negedge clk);
        op    = o;
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        e.tag = tag;
        e.out = eo;
        e.inv = ei;
        e.due = cyc + lat;
        e.lat = lat;
        sbq.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic raw_start(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op    = o;
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d results outstanding expected 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        in_a  = '0;
        in_b  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out", out, '0);
        check("reset invalid", W'(invalid), '0);
        check("reset busy", W'(busy), '0);
        check("reset done", W'(done), '0);
        reset = 1'b0;

        issue("add_wrap", 5'b00000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
        issue("sub_b2b", 5'b01000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1);
        wait_idle(10);

        issue("sra4", 5'b01101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 4);
        wait_idle(20);
        issue("sll0", 5'b00001, 32'h0000_0001, 32'd0, 32'h0000_0001, 1'b0, 1);
        issue("srl1", 5'b00101, 32'hF000_0000, 32'd1, 32'h7800_0000, 1'b0, 1);
        wait_idle(10);
        issue("sll31", 5'b00001, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 31);
        wait_idle(60);

        issue("slt", 5'b00010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
        issue("sltu", 5'b00011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
        issue("xor", 5'b00100, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1);
        issue("or", 5'b00110, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1);
        issue("and", 5'b00111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
        issue("inv_01001", 5'b01001, 32'h1234_5678, 32'h1, 32'h0000_0000, 1'b1, 1);
        issue("add_clr", 5'b00000, 32'd2, 32'd3, 32'd5, 1'b0, 1);
        wait_idle(10);

`ifdef ALU_MULDIV_EN
        issue("mulhu", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        issue("mul", 5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
        wait_idle(100);
        issue("mul_small", 5'b10000, 32'd3, 32'd5, 32'd15, 1'b0, 33);
        issue("mulh", 5'b10001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 33);
        issue("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
        wait_idle(150);
        issue("div_by0", 5'b10100, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        issue("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        issue("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1);
        issue("remu_by0", 5'b10111, 32'd7, 32'd0, 32'd7, 1'b0, 1);
        issue("inv_11000", 5'b11000, 32'd7, 32'd1, 32'd0, 1'b1, 1);
        wait_idle(10);
        issue("rem_neg", 5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        issue("div_neg", 5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        issue("divu", 5'b10101, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        wait_idle(150);
`else
        issue("inv_10000", 5'b10000, 32'd3, 32'd5, 32'd0, 1'b1, 1);
        issue("inv_10101", 5'b10101, 32'd100, 32'd7, 32'd0, 1'b1, 1);
        wait_idle(10);
`endif

        // A start while busy must be dropped and leave the shift result intact
        issue("srl8_busy", 5'b00101, 32'h8000_0000, 32'd8, 32'h0080_0000, 1'b0, 8);
        repeat (2) @(negedge clk);
        raw_start(5'b00000, 32'd1, 32'd1);
        wait_idle(30);

`ifdef ALU_MULDIV_EN
        raw_start(5'b10101, 32'd100, 32'd7);
`else
        raw_start(5'b00101, 32'hFFFF_FFFF, 32'd31);
`endif
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort out", out, '0);
        check("abort invalid", W'(invalid), '0);
        check("abort busy", W'(busy), '0);
        check("abort done", W'(done), '0);
        repeat (50) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle, parametrised successor to the single-cycle RV32I/E ALU. It accepts one operation per start strobe and computes shifts iteratively, one bit per cycle. When `ALU_MULDIV_EN` is defined, it also executes the RV32M multiply/divide group with shift-add and restoring-divide sequencers. It sits in the execute stage; the pipeline controller stalls on `busy` and consumes the result on `done`.

## Interface
- `DATA_WIDTH`, default 32: operand/result width; power of two, at least 8. Shift amount width is SW = $clog2(DATA_WIDTH).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only when `busy`=0.
- `op`  in  5  operation code, latched on accept.
- `in_a`  in  DATA_WIDTH  operand A, latched on accept.
- `in_b`  in  DATA_WIDTH  operand B, latched on accept.
- `out`  out  DATA_WIDTH  result; holds its value until the next completion.
- `invalid`  out  1  set with `done` for an unsupported `op`; holds until the next completion.
- `busy`  out  1  a multi-cycle operation is in flight.
- `done`  out  1  one-cycle pulse; `out` and `invalid` are updated in the same cycle.

## Operation
- Base ops, `op[4]`=0, `op[3:0]`:
  - 0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1101 SRA.
  - All other codes are invalid.
- M ops, `op[4]`=1, `op[3]`=0, `op[2:0]`:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - `op[3]`=1 is invalid.
- States and transitions:
  - IDLE → SHIFT, MUL or DIV on accept of a multi-cycle op.
  - SHIFT, MUL and DIV each return to IDLE on their final iteration, with `done` asserted.
  - `busy` = (state != IDLE).
- Single-cycle class: ADD, SUB, logic, SLT, SLTU, invalid codes, and shifts with amount 0.
- SHIFT:
  - Amount is `in_b[SW-1:0]`; a down-counter is loaded with the amount.
  - Each cycle shifts by 1 bit; SRA replicates the sign bit.
- MUL:
  - Operands are converted to magnitudes per signedness (MULH: both signed; MULHSU: A signed; MULHU/MUL: unsigned).
  - Runs DATA_WIDTH shift-add iterations into a 2×DATA_WIDTH accumulator.
  - A final cycle negates the product if required and selects the low half (MUL) or high half (others).
- DIV:
  - Restoring division over DATA_WIDTH iterations on magnitudes.
  - A final cycle applies sign fixup: quotient sign = sign(A) XOR sign(B); remainder takes the sign of A.
- DIV special cases complete single-cycle (early out), with no iteration:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return A.
  - Signed overflow (A = most-negative, B = −1): DIV returns A; REM returns 0.
- Invalid op: `out`=0, `invalid`=1. Any valid completion clears `invalid`.
- `start` while `busy`=1 is ignored; no queuing.

## Timing
- Reset values:
  - `out`=0, `invalid`=0, `busy`=0, `done`=0; state IDLE.
  - Counters and accumulators are cleared.
- Reset in any state aborts the operation; no `done` is produced for it.
- Latency is measured from the accept edge T, i.e. the edge where `start`=1 and `busy`=0:
  - Single-cycle class: `done` at T+1; `busy` never rises.
  - Shift by n≥1: `busy`=1 for T+1..T+n−1; `done` at T+n with `busy`=0.
  - MUL group: `done` at T+DATA_WIDTH+1.
  - DIV group: `done` at T+DATA_WIDTH+1; special cases at T+1.
- Back-to-back: a `start` in the `done` cycle is accepted, giving full throughput for single-cycle ops.
- `out` and `invalid` change only in `done` cycles or on reset.

## Configuration
- `ALU_MULDIV_EN` defined:
  - The MUL and DIV states, datapaths and M-op decode are compiled in.
- `ALU_MULDIV_EN` undefined:
  - Any `op[4]`=1 is an invalid op: single-cycle, `invalid`=1, `out`=0.
  - No multiplier/divider logic is generated.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001, then a `start` in the `done` cycle with SUB 0 − 1 → `out`=0x00000000 at T+1, then 0xFFFFFFFF at T+2; `busy` stays 0.
- SRA 0x80000000 by 4 → `busy` for 3 cycles, `out`=0xF8000000 at T+4. SLL 0x1 by 0 → `out`=0x1 at T+1.
- With `ALU_MULDIV_EN`: MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE at T+33; MUL of the same operands → 0x00000001.
- With `ALU_MULDIV_EN`:
  - DIV 7 / 0 → 0xFFFFFFFF at T+1.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1.
  - REM −7 / 2 → 0xFFFFFFFF (−1) at T+33.
- `op`=5'b01001 → `invalid`=1, `out`=0 at T+1; a following ADD clears `invalid`. Without `ALU_MULDIV_EN`, `op`=5'b10000 → `invalid`=1 at T+1.
- Start DIVU, pulse `reset` at T+10 → all outputs 0 and no `done`. Separately, a second `start` during `busy` is ignored and the first result is intact.
